// File: rtl/vnu_accum.sv
// ----------------------------------------------------------------------------
// vnu_accum : variable-node accumulator of the shuffled-VNU datapath.
//
// Adds the channel LLR to dv check-to-variable messages, then streams the dv
// extrinsic messages (total - msg_k) out. Each extrinsic is symmetrically
// saturated to [-(2^(W-1)-1), +(2^(W-1)-1)] in two's complement. Also
// produces the hard decision of the variable node.
//
// Optional feature macro: VNU_APP_OUT_EN (adds o_app = sat(total) with o_done)
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      start pulse, sampled only in IDLE
//   i_llr        channel LLR (CH_W, two's complement), sampled with i_start
//   i_dv         node degree, sampled with i_start, clamped to DV_MAX
//   i_msg        check-to-variable message (W)
//   i_msg_valid  i_msg valid; accepted every cycle in ACC
//   o_data       extrinsic message k (W)
//   o_valid      o_data valid
//   i_ready      downstream accepts o_data
//   o_done       one-cycle pulse when the node is finished
//   o_hard       hard decision (1 = total < 0), valid with o_done
//   o_app        (VNU_APP_OUT_EN only) saturated total, valid with o_done
// ----------------------------------------------------------------------------
module vnu_accum #(
  parameter int W      = 11,
  parameter int CH_W   = 8,
  parameter int DV_MAX = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [CH_W-1:0]               i_llr,
  input  logic [$clog2(DV_MAX+1)-1:0]   i_dv,
  input  logic [W-1:0]                  i_msg,
  input  logic                          i_msg_valid,
  output logic [W-1:0]                  o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_done,
  output logic                          o_hard
`ifdef VNU_APP_OUT_EN
  ,
  output logic [W-1:0]                  o_app
`endif
);

  localparam int DW = $clog2(DV_MAX + 1);
  localparam int AW = W + DW;
  localparam int IW = (DV_MAX > 1) ? $clog2(DV_MAX) : 1;

  // Symmetric clamp limits in accumulator width
  localparam logic signed [AW-1:0] P_MAX = {{(DW + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [AW-1:0] P_MIN = -P_MAX;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  function automatic logic [AW-1:0] sext_msg(input logic [W-1:0] m);
    sext_msg = {{(AW - W){m[W-1]}}, m};
  endfunction

  function automatic logic [AW-1:0] sext_llr(input logic [CH_W-1:0] l);
    sext_llr = {{(AW - CH_W){l[CH_W-1]}}, l};
  endfunction

  function automatic logic [W-1:0] sat_msg(input logic signed [AW-1:0] v);
    logic [W-1:0] r;
    if (v > P_MAX) begin
      r = P_MAX[W-1:0];
    end else if (v < P_MIN) begin
      r = P_MIN[W-1:0];
    end else begin
      r = v[W-1:0];
    end
    sat_msg = r;
  endfunction

  state_t         r_state;
  state_t         w_state_nxt;
  logic [AW-1:0]  r_total;
  logic [AW-1:0]  w_total_nxt;
  logic [DW-1:0]  r_dv;
  logic [DW-1:0]  w_dv_nxt;
  logic [DW-1:0]  r_cnt;
  logic [DW-1:0]  w_cnt_nxt;
  logic [W-1:0]   r_data;
  logic [W-1:0]   w_data_nxt;
  logic           r_valid;
  logic           w_valid_nxt;
  logic           r_done;
  logic           w_done_nxt;
  logic           r_hard;
  logic           w_hard_nxt;
  logic [W-1:0]   r_buf [DV_MAX];
  logic           w_buf_we;
  logic [DW-1:0]  w_dv_clamp;
  logic [DW-1:0]  w_cnt_inc;
  logic [AW-1:0]  w_acc_sum;
  logic [W-1:0]   w_buf0;
  logic [W-1:0]   w_next_msg;
`ifdef VNU_APP_OUT_EN
  logic [W-1:0]   r_app;
  logic [W-1:0]   w_app_nxt;
`endif

  // Next-state and next-output computation for the IDLE/ACC/OUT controller
  always_comb begin
    w_state_nxt = r_state;
    w_total_nxt = r_total;
    w_dv_nxt    = r_dv;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    w_hard_nxt  = 1'b0;
    w_buf_we    = 1'b0;
`ifdef VNU_APP_OUT_EN
    w_app_nxt   = {W{1'b0}};
`endif
    w_dv_clamp = (i_dv > DW'(DV_MAX)) ? DW'(DV_MAX) : i_dv;
    w_cnt_inc  = r_cnt + DW'(1'b1);
    w_acc_sum  = r_total + sext_msg(i_msg);
    // The first extrinsic is formed in the same cycle message 0 may be written
    w_buf0     = (r_cnt == {DW{1'b0}}) ? i_msg : r_buf[0];
    w_next_msg = r_buf[w_cnt_inc[IW-1:0]];

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_total_nxt = sext_llr(i_llr);
          w_dv_nxt    = w_dv_clamp;
          w_cnt_nxt   = {DW{1'b0}};
          if (w_dv_clamp == {DW{1'b0}}) begin
            w_done_nxt = 1'b1;
            w_hard_nxt = i_llr[CH_W-1];
`ifdef VNU_APP_OUT_EN
            w_app_nxt  = sat_msg(sext_llr(i_llr));
`endif
          end else begin
            w_state_nxt = S_ACC;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACC: begin
        if (i_msg_valid) begin
          w_buf_we    = 1'b1;
          w_total_nxt = w_acc_sum;
          if (w_cnt_inc == r_dv) begin
            w_state_nxt = S_OUT;
            w_cnt_nxt   = {DW{1'b0}};
            w_valid_nxt = 1'b1;
            w_data_nxt  = sat_msg(w_acc_sum - sext_msg(w_buf0));
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_state_nxt = S_ACC;
        end
      end
      S_OUT: begin
        if (r_valid && i_ready) begin
          if (w_cnt_inc == r_dv) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_cnt_nxt   = {DW{1'b0}};
            w_data_nxt  = {W{1'b0}};
            w_done_nxt  = 1'b1;
            w_hard_nxt  = r_total[AW-1];
`ifdef VNU_APP_OUT_EN
            w_app_nxt   = sat_msg(r_total);
`endif
          end else begin
            w_cnt_nxt  = w_cnt_inc;
            w_data_nxt = sat_msg(r_total - sext_msg(w_next_msg));
          end
        end else begin
          w_state_nxt = S_OUT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_cnt_nxt   = {DW{1'b0}};
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_total <= {AW{1'b0}};
      r_dv    <= {DW{1'b0}};
      r_cnt   <= {DW{1'b0}};
      r_data  <= {W{1'b0}};
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_hard  <= 1'b0;
`ifdef VNU_APP_OUT_EN
      r_app   <= {W{1'b0}};
`endif
    end else begin
      r_total <= w_total_nxt;
      r_dv    <= w_dv_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_hard  <= w_hard_nxt;
`ifdef VNU_APP_OUT_EN
      r_app   <= w_app_nxt;
`endif
    end
  end

  // Message buffer, written in arrival order during ACC
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DV_MAX; i++) begin
        r_buf[i] <= {W{1'b0}};
      end
    end else if (w_buf_we) begin
      r_buf[r_cnt[IW-1:0]] <= i_msg;
    end else begin
      r_buf <= r_buf;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_done  = r_done;
  assign o_hard  = r_hard;
`ifdef VNU_APP_OUT_EN
  assign o_app   = r_app;
`endif

endmodule

// File: tb/tb_vnu_accum.sv
module tb_vnu_accum;

  typedef logic [7:0][15:0] v8_t;

  typedef struct packed {
    logic signed [15:0] llr;
    logic [3:0]         dv;
    v8_t                msgs;
    v8_t                exp;
    logic               hard;
    logic signed [15:0] app;
  } vec_t;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [7:0]  i_llr;
  logic [3:0]  i_dv;
  logic [10:0] i_msg;
  logic        i_msg_valid;
  logic [10:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_done;
  logic        o_hard;
`ifdef VNU_APP_OUT_EN
  logic [10:0] o_app;
`endif

  int n_checks;
  int n_err;
  vec_t tbl [9];

  vnu_accum dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_llr       (i_llr),
    .i_dv        (i_dv),
    .i_msg       (i_msg),
    .i_msg_valid (i_msg_valid),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_done      (o_done),
    .o_hard      (o_hard)
`ifdef VNU_APP_OUT_EN
    ,
    .o_app       (o_app)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 1023) return 1023;
    if (v < -1023) return -1023;
    return v;
  endfunction

  function automatic v8_t pk(input int a0, input int a1, input int a2, input int a3,
                             input int a4, input int a5, input int a6, input int a7);
    v8_t r;
    r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
    r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6); r[7] = 16'(a7);
    return r;
  endfunction

  // Runs one node: start, messages, output stream, completion
  task automatic run_node(input int llr, input int dv, input v8_t msgs, input v8_t exp,
                          input int hard, input int app, input int stall_at,
                          input int stall_len, input bit rnd);
    int n;
    int k;
    int cyc;
    int held;
    n = (dv > 8) ? 8 : dv;
    i_llr = 8'(llr);
    i_dv = 4'(dv);
    i_start = 1'b1;
    i_msg_valid = 1'b0;
    i_ready = 1'b0;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    if (n == 0) begin
      chk("dv0_done", int'(o_done), 1);
      chk("dv0_hard", int'(o_hard), hard);
      chk("dv0_valid", int'(o_valid), 0);
`ifdef VNU_APP_OUT_EN
      chk("dv0_app", int'($signed(o_app)), app);
`endif
      for (int c = 0; c < 2; c++) begin
        i_msg_valid = 1'b1;
        i_msg = 11'(c + 100);
        @(posedge i_clk); #1;
        chk("dv0_quiet_valid", int'(o_valid), 0);
        chk("dv0_quiet_done", int'(o_done), 0);
      end
      i_msg_valid = 1'b0;
    end else begin
      chk("start_done_low", int'(o_done), 0);
      for (int m = 0; m < n; m++) begin
        if (rnd) begin
          int gaps;
          gaps = $urandom_range(0, 2);
          for (int g = 0; g < gaps; g++) begin
            i_msg_valid = 1'b0;
            i_start = 1'($urandom_range(0, 1));
            i_llr = 8'($urandom);
            @(posedge i_clk); #1;
            chk("acc_gap_valid_low", int'(o_valid), 0);
          end
        end
        i_msg_valid = 1'b1;
        i_msg = 11'(msgs[m]);
        i_start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge i_clk); #1;
        if (m < n - 1) chk("acc_valid_low", int'(o_valid), 0);
      end
      i_msg_valid = 1'b0;
      i_start = 1'b0;
      k = 0;
      cyc = 0;
      held = 0;
      while (k < n && cyc < 300) begin
        if (k == stall_at && held < stall_len) begin
          i_ready = 1'b0;
          held++;
        end else if (rnd) begin
          i_ready = ($urandom_range(0, 2) != 0);
        end else begin
          i_ready = 1'b1;
        end
        if (rnd) begin
          i_start = 1'($urandom_range(0, 1));
          i_msg_valid = 1'($urandom_range(0, 1));
          i_msg = 11'($urandom);
        end
        chk("out_valid", int'(o_valid), 1);
        chk($sformatf("out_data[%0d]", k), int'($signed(o_data)), int'($signed(exp[k])));
        @(posedge i_clk); #1;
        if (i_ready) k++;
        cyc++;
      end
      if (k < n) chk("out_timeout", k, n);
      i_ready = 1'b0;
      i_start = 1'b0;
      i_msg_valid = 1'b0;
      chk("end_valid", int'(o_valid), 0);
      chk("end_done", int'(o_done), 1);
      chk("end_hard", int'(o_hard), hard);
`ifdef VNU_APP_OUT_EN
      chk("end_app", int'($signed(o_app)), app);
`endif
    end
  endtask

  initial begin
    n_checks = 0;
    n_err = 0;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_llr = 8'd0;
    i_dv = 4'd0;
    i_msg = 11'd0;
    i_msg_valid = 1'b0;
    i_ready = 1'b0;
    #12;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_hard", int'(o_hard), 0);
`ifdef VNU_APP_OUT_EN
    chk("rst_app", int'(o_app), 0);
`endif
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // {llr, dv, msgs, expected extrinsics, hard, app}
    tbl[0] = '{16'sd5, 4'd3, pk(10, -4, 7, 0, 0, 0, 0, 0), pk(8, 22, 11, 0, 0, 0, 0, 0), 1'b0, 16'sd18};
    tbl[1] = '{16'sd127, 4'd2, pk(1023, 1023, 0, 0, 0, 0, 0, 0), pk(1023, 1023, 0, 0, 0, 0, 0, 0), 1'b0, 16'sd1023};
    tbl[2] = '{-16'sd128, 4'd2, pk(-1024, -1024, 0, 0, 0, 0, 0, 0), pk(-1023, -1023, 0, 0, 0, 0, 0, 0), 1'b1, -16'sd1023};
    tbl[3] = '{-16'sd3, 4'd0, pk(0, 0, 0, 0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, -16'sd3};
    tbl[4] = '{16'sd0, 4'd1, pk(0, 0, 0, 0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 16'sd0};
    tbl[5] = '{16'sd4, 4'd1, pk(-4, 0, 0, 0, 0, 0, 0, 0), pk(4, 0, 0, 0, 0, 0, 0, 0), 1'b0, 16'sd0};
    tbl[6] = '{16'sd0, 4'd12, pk(1, 2, 3, 4, 5, 6, 7, 8), pk(35, 34, 33, 32, 31, 30, 29, 28), 1'b0, 16'sd36};
    tbl[7] = '{-16'sd1, 4'd2, pk(0, 1, 0, 0, 0, 0, 0, 0), pk(0, -1, 0, 0, 0, 0, 0, 0), 1'b0, 16'sd0};
    tbl[8] = '{16'sd1, 4'd2, pk(-1, -1, 0, 0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, -16'sd1};

    for (int i = 0; i < 9; i++) begin
      run_node(int'(tbl[i].llr), int'(tbl[i].dv), tbl[i].msgs, tbl[i].exp,
               int'(tbl[i].hard), int'(tbl[i].app), -1, 0, 1'b0);
    end

    // Downstream stall of 5 cycles on the second output
    run_node(int'(tbl[0].llr), int'(tbl[0].dv), tbl[0].msgs, tbl[0].exp,
             int'(tbl[0].hard), int'(tbl[0].app), 1, 5, 1'b0);

    // Asynchronous reset in the middle of the output stream
    i_ready = 1'b1;
    i_llr = 8'd5;
    i_dv = 4'd3;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_msg_valid = 1'b1;
    i_msg = 11'd10;
    @(posedge i_clk); #1;
    i_msg = -11'sd4;
    @(posedge i_clk); #1;
    i_msg = 11'd7;
    @(posedge i_clk); #1;
    i_msg_valid = 1'b0;
    chk("rstmid_first", int'($signed(o_data)), 8);
    @(posedge i_clk); #1;
    chk("rstmid_second", int'($signed(o_data)), 22);
    #3;
    i_rst = 1'b1;
    #1;
    chk("rstmid_valid", int'(o_valid), 0);
    chk("rstmid_data", int'(o_data), 0);
    chk("rstmid_done", int'(o_done), 0);
    chk("rstmid_hard", int'(o_hard), 0);
`ifdef VNU_APP_OUT_EN
    chk("rstmid_app", int'(o_app), 0);
`endif
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_ready = 1'b0;
    @(posedge i_clk); #1;
    chk("after_rst_valid", int'(o_valid), 0);
    run_node(int'(tbl[0].llr), int'(tbl[0].dv), tbl[0].msgs, tbl[0].exp,
             int'(tbl[0].hard), int'(tbl[0].app), -1, 0, 1'b0);

    // Randomized nodes against the arithmetic reference model
    for (int r = 0; r < 40; r++) begin
      int dv;
      int n;
      int llr;
      int total;
      int ms [8];
      v8_t pm;
      v8_t pe;
      dv = $urandom_range(0, 10);
      n = (dv > 8) ? 8 : dv;
      llr = int'($urandom_range(0, 255)) - 128;
      total = llr;
      pm = '0;
      pe = '0;
      for (int i = 0; i < 8; i++) ms[i] = 0;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) ms[i] = ($urandom_range(0, 1) != 0) ? 1023 : -1024;
        else ms[i] = int'($urandom_range(0, 2047)) - 1024;
        total += ms[i];
        pm[i] = 16'(ms[i]);
      end
      for (int i = 0; i < n; i++) pe[i] = 16'(clamp(total - ms[i]));
      run_node(llr, dv, pm, pe, (total < 0) ? 1 : 0, clamp(total), -1, 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
